// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The slave modport is the ALU side; master is the datapath driving operands and taking results.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       S;
   logic             S2;
   logic             ACC_SEL;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] F;
   logic             C;
   logic             Z;
   logic             N;
   logic             V;

   modport slave (
      input  in_valid, A, B, S, S2, ACC_SEL, out_ready,
      output in_ready, out_valid, F, C, Z, N, V
   );

   modport master (
      output in_valid, A, B, S, S2, ACC_SEL, out_ready,
      input  in_ready, out_valid, F, C, Z, N, V
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, C/Z/N/V flags and accumulator chaining.
// Optional ALU_PIPE_SAT_EN: arithmetic results saturate unsigned instead of wrapping.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_pipe_if.slave   bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [1:0]       s1_s;
   logic             s1_s2;
   logic             s1_acc;

   logic             out_valid_q;
   logic [WIDTH-1:0] f_q;
   logic             c_q, z_q, n_q, v_q;

   logic             in_ready;
   logic             advance;

   logic [WIDTH-1:0] ae;
   logic [WIDTH-1:0] opb;
   logic [WIDTH:0]   ext;
   logic [WIDTH-1:0] res;
   logic             sub;
   logic             c_nx;
   logic             v_nx;

   assign in_ready = !s1_valid || !out_valid_q || bus.out_ready;
   assign advance  = s1_valid && (!out_valid_q || bus.out_ready);

   // The accumulator is f_q itself; it still holds the old result on the cycle it is handed off.
   always_comb begin
      ae   = s1_acc ? f_q : s1_a;
      sub  = s1_s[0];
      opb  = s1_s[1] ? ONE : s1_b;
      ext  = sub ? ({1'b0, ae} - {1'b0, opb}) : ({1'b0, ae} + {1'b0, opb});
      res  = '0;
      c_nx = 1'b0;
      v_nx = 1'b0;
      if (s1_s2 == 1'b1) begin
         case (s1_s)
            2'b00:   res = ae & s1_b;
            2'b01:   res = ae | s1_b;
            2'b10:   res = ae ^ s1_b;
            default: res = ~ae;
         endcase
      end else begin
         res  = ext[WIDTH-1:0];
         c_nx = ext[WIDTH];
         v_nx = sub ? ((ae[WIDTH-1] ^ opb[WIDTH-1]) & (ae[WIDTH-1] ^ ext[WIDTH-1]))
                    : (~(ae[WIDTH-1] ^ opb[WIDTH-1]) & (ae[WIDTH-1] ^ ext[WIDTH-1]));
`ifdef ALU_PIPE_SAT_EN
         if (c_nx) res = sub ? '0 : '1;
`else
         res = ext[WIDTH-1:0];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_s     <= '0;
         s1_s2    <= 1'b0;
         s1_acc   <= 1'b0;
      end else if (bus.in_valid && in_ready) begin
         s1_valid <= 1'b1;
         s1_a     <= bus.A;
         s1_b     <= bus.B;
         s1_s     <= bus.S;
         s1_s2    <= bus.S2;
         s1_acc   <= bus.ACC_SEL;
      end else if (advance) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         f_q         <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
      end else if (advance) begin
         out_valid_q <= 1'b1;
         f_q         <= res;
         c_q         <= c_nx;
         z_q         <= (res == '0);
         n_q         <= res[WIDTH-1];
         v_q         <= v_nx;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.F         = f_q;
   assign bus.C         = c_q;
   assign bus.Z         = z_q;
   assign bus.N         = n_q;
   assign bus.V         = v_q;
endmodule
